// File: rtl/airi5c_fpu_result_collector_pkg.sv
// Shared FPU definitions: unit IDs, fflags bit positions and the collector's state encoding.
package airi5c_fpu_result_collector_pkg;

    localparam int FPU_UNIT_CMP = 0;
    localparam int FPU_UNIT_ADD = 1;
    localparam int FPU_UNIT_MUL = 2;
    localparam int FPU_UNIT_DIV = 3;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;
    localparam int FFLAGS_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/airi5c_fpu_result_collector.sv
// Collects the result of the single outstanding FP operation, accrues fflags and
// presents the result to the core writeback with a valid/ready handshake.
//   state   | meaning
//   ST_IDLE | nothing outstanding, accepts issue
//   ST_WAIT | waiting for the issued unit's ready pulse, watchdog running
//   ST_HOLD | result held on wb_data until wb_ready
module airi5c_fpu_result_collector
    import airi5c_fpu_result_collector_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int TIMEOUT = 64,
    localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
    localparam int CW = $clog2(TIMEOUT)
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      kill,
    input  logic                      issue,
    input  logic [UW-1:0]             issue_unit,
    input  logic                      issue_int_dest,
    input  logic [N_UNITS-1:0]        unit_ready,
    input  logic [32*N_UNITS-1:0]     unit_result,
    input  logic [5*N_UNITS-1:0]      unit_flags,
    input  logic                      wb_ready,
    output logic                      wb_valid,
    output logic [31:0]               wb_data,
    output logic                      wb_int_dest,
    output logic                      busy,
    input  logic                      csr_we,
    input  logic [FFLAGS_W-1:0]       csr_wdata,
    output logic [FFLAGS_W-1:0]       fflags,
    output logic                      timeout_err
);

    state_e              state_q, state_d;
    logic [UW-1:0]       sel_q, sel_d;
    logic                pend_int_q, pend_int_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                wb_valid_q, wb_valid_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic                wb_int_dest_q, wb_int_dest_d;
    logic                busy_q, busy_d;
    logic [FFLAGS_W-1:0] fflags_q, fflags_d;
    logic                timeout_q, timeout_d;

    logic                sel_ready;
    logic [31:0]         sel_result;
    logic [FFLAGS_W-1:0] sel_flags;
    logic [FFLAGS_W-1:0] fflags_base;

    assign sel_ready  = unit_ready[sel_q];
    assign sel_result = unit_result[32*sel_q +: 32];
    assign sel_flags  = unit_flags[5*sel_q +: 5];

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        pend_int_d    = pend_int_q;
        cnt_d         = cnt_q;
        wb_data_d     = wb_data_q;
        wb_int_dest_d = wb_int_dest_q;
        timeout_d     = 1'b0;
        // a CSR write replaces the accrued flags but still merges a same-cycle capture
        fflags_base   = csr_we ? csr_wdata : fflags_q;
        fflags_d      = fflags_base;

        if (kill) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        sel_d      = issue_unit;
                        pend_int_d = issue_int_dest;
                        cnt_d      = '0;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sel_ready) begin
                        wb_data_d     = sel_result;
                        wb_int_dest_d = pend_int_q;
                        fflags_d      = fflags_base | sel_flags;
                        state_d       = ST_HOLD;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (wb_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        wb_valid_d = (state_d == ST_HOLD);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            pend_int_q    <= 1'b0;
            cnt_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_int_dest_q <= 1'b0;
            busy_q        <= 1'b0;
            fflags_q      <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            pend_int_q    <= pend_int_d;
            cnt_q         <= cnt_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_int_dest_q <= wb_int_dest_d;
            busy_q        <= busy_d;
            fflags_q      <= fflags_d;
            timeout_q     <= timeout_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_int_dest = wb_int_dest_q;
    assign busy        = busy_q;
    assign fflags      = fflags_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_airi5c_fpu_result_collector.sv
// Directed and randomized checks of the FPU result collector against a transaction-level model.
module tb_airi5c_fpu_result_collector;

    localparam int N_UNITS = 4;
    localparam int TIMEOUT = 64;

    logic                   clk = 1'b0;
    logic                   n_reset;
    logic                   kill;
    logic                   issue;
    logic [1:0]             issue_unit;
    logic                   issue_int_dest;
    logic [N_UNITS-1:0]     unit_ready;
    logic [32*N_UNITS-1:0]  unit_result;
    logic [5*N_UNITS-1:0]   unit_flags;
    logic                   wb_ready;
    logic                   wb_valid;
    logic [31:0]            wb_data;
    logic                   wb_int_dest;
    logic                   busy;
    logic                   csr_we;
    logic [4:0]             csr_wdata;
    logic [4:0]             fflags;
    logic                   timeout_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rres [N_UNITS];
    logic [4:0]  rflg [N_UNITS];

    airi5c_fpu_result_collector #(.N_UNITS(N_UNITS), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .kill           (kill),
        .issue          (issue),
        .issue_unit     (issue_unit),
        .issue_int_dest (issue_int_dest),
        .unit_ready     (unit_ready),
        .unit_result    (unit_result),
        .unit_flags     (unit_flags),
        .wb_ready       (wb_ready),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_int_dest    (wb_int_dest),
        .busy           (busy),
        .csr_we         (csr_we),
        .csr_wdata      (csr_wdata),
        .fflags         (fflags),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        issue      = 1'b0;
        kill       = 1'b0;
        unit_ready = '0;
        csr_we     = 1'b0;
        wb_ready   = 1'b0;
    endtask

    task automatic drive_units();
        for (int k = 0; k < N_UNITS; k++) begin
            unit_result[32*k +: 32] = rres[k];
            unit_flags[5*k +: 5]    = rflg[k];
        end
    endtask

    task automatic start(input int u, input logic idst);
        issue          = 1'b1;
        issue_unit     = 2'(u);
        issue_int_dest = idst;
        step();
        issue = 1'b0;
    endtask

    int          u, o, lat, dly, cyc;
    logic        idst, kk, cw, seen;
    logic [4:0]  wd;
    logic [4:0]  exp_ff;
    logic [31:0] exp_data;
    logic        exp_int;

    initial begin
        n_reset = 1'b0;
        quiet();
        issue_unit     = '0;
        issue_int_dest = 1'b0;
        csr_wdata      = '0;
        unit_result    = '0;
        unit_flags     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_reset = 1'b1;
        step();

        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_int_dest", 32'(wb_int_dest), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fflags", 32'(fflags), 0);
        chk("rst_timeout", 32'(timeout_err), 0);

        // comparator to integer RF, wb_ready already high
        start(0, 1'b1);
        chk("t1_busy", 32'(busy), 1);
        unit_ready[0] = 1'b1;
        unit_result[31:0] = 32'h0000_0001;
        unit_flags[4:0] = 5'b10000;
        wb_ready = 1'b1;
        step();
        unit_ready = '0;
        chk("t1_valid", 32'(wb_valid), 1);
        chk("t1_data", wb_data, 32'h1);
        chk("t1_int", 32'(wb_int_dest), 1);
        chk("t1_fflags", 32'(fflags), 5'b10000);
        step();
        wb_ready = 1'b0;
        chk("t1_valid_drop", 32'(wb_valid), 0);
        chk("t1_busy_drop", 32'(busy), 0);

        // div/sqrt with delayed handshake
        csr_we = 1'b1; csr_wdata = 5'b0;
        step();
        csr_we = 1'b0;
        chk("t2_clear", 32'(fflags), 0);
        start(3, 1'b0);
        step();
        unit_ready[3] = 1'b1;
        unit_result[96 +: 32] = 32'h3F80_0000;
        unit_flags[15 +: 5] = 5'b00001;
        step();
        unit_ready = '0;
        unit_result[96 +: 32] = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_valid", 32'(wb_valid), 1);
            chk("t2_hold_data", wb_data, 32'h3F80_0000);
            step();
        end
        chk("t2_fflags", 32'(fflags), 5'b00001);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("t2_valid_drop", 32'(wb_valid), 0);

        // non-selected unit ready is ignored
        csr_we = 1'b1; csr_wdata = 5'b0;
        step();
        csr_we = 1'b0;
        start(2, 1'b0);
        unit_ready[1] = 1'b1;
        unit_result[32 +: 32] = 32'h1111_1111;
        unit_flags[5 +: 5] = 5'b00100;
        step();
        unit_ready = '0;
        chk("t3_no_valid", 32'(wb_valid), 0);
        chk("t3_no_accrue", 32'(fflags), 0);
        unit_ready[2] = 1'b1;
        unit_result[64 +: 32] = 32'h4000_0000;
        unit_flags[10 +: 5] = 5'b0;
        step();
        unit_ready = '0;
        chk("t3_data", wb_data, 32'h4000_0000);
        chk("t3_fflags", 32'(fflags), 0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // kill beats a same-cycle ready
        start(1, 1'b0);
        unit_ready[1] = 1'b1;
        unit_flags[5 +: 5] = 5'b00010;
        kill = 1'b1;
        step();
        quiet();
        chk("t4_valid", 32'(wb_valid), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_fflags", 32'(fflags), 0);

        // kill beats issue in IDLE
        kill = 1'b1;
        start(0, 1'b0);
        kill = 1'b0;
        chk("kill_issue_busy", 32'(busy), 0);

        // watchdog
        start(3, 1'b0);
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 2 * TIMEOUT && !seen; c++) begin
            step();
            if (timeout_err) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        chk("t5_timeout_cycle", 32'(cyc), TIMEOUT);
        chk("t5_busy", 32'(busy), 0);
        step();
        chk("t5_pulse_once", 32'(timeout_err), 0);
        start(0, 1'b0);
        chk("t5_reissue", 32'(busy), 1);
        kill = 1'b1;
        step();
        kill = 1'b0;

        // ready on the last watchdog cycle wins
        start(2, 1'b0);
        repeat (TIMEOUT - 1) step();
        unit_ready[2] = 1'b1;
        unit_result[64 +: 32] = 32'h1234_5678;
        unit_flags[10 +: 5] = 5'b00100;
        step();
        unit_ready = '0;
        chk("edge_valid", 32'(wb_valid), 1);
        chk("edge_no_timeout", 32'(timeout_err), 0);
        chk("edge_data", wb_data, 32'h1234_5678);
        chk("edge_fflags", 32'(fflags), 5'b00100);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // csr write merged with a capture
        csr_we = 1'b1; csr_wdata = 5'b00001;
        step();
        csr_we = 1'b0;
        chk("t6_csr", 32'(fflags), 5'b00001);
        start(1, 1'b0);
        unit_ready[1] = 1'b1;
        unit_flags[5 +: 5] = 5'b01000;
        csr_we = 1'b1; csr_wdata = 5'b0;
        step();
        quiet();
        chk("t6_merge", 32'(fflags), 5'b01000);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // reset mid-operation
        start(3, 1'b1);
        n_reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_fflags", 32'(fflags), 0);
        step();
        n_reset = 1'b1;
        step();

        // randomized operations against a transaction-level model
        exp_ff   = 5'b0;
        exp_data = 32'h0;
        exp_int  = 1'b0;
        for (int op = 0; op < 80; op++) begin
            u    = $urandom_range(0, N_UNITS - 1);
            idst = 1'($urandom_range(0, 1));
            lat  = $urandom_range(0, 6);
            for (int k = 0; k < N_UNITS; k++) begin
                rres[k] = $urandom;
                rflg[k] = 5'($urandom);
            end
            drive_units();
            start(u, idst);
            chk("r_busy", 32'(busy), 1);
            for (int c = 0; c < lat; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    o = (u + 1 + $urandom_range(0, N_UNITS - 2)) % N_UNITS;
                    unit_ready[o] = 1'b1;
                end
                step();
                unit_ready = '0;
                chk("r_wait_valid", 32'(wb_valid), 0);
                chk("r_wait_fflags", 32'(fflags), 32'(exp_ff));
            end
            for (int k = 0; k < N_UNITS; k++) begin
                rres[k] = $urandom;
                rflg[k] = 5'($urandom);
            end
            drive_units();
            unit_ready    = 4'($urandom);
            unit_ready[u] = 1'b1;
            kk = ($urandom_range(0, 9) == 0);
            cw = ($urandom_range(0, 4) == 0);
            wd = 5'($urandom);
            kill      = kk;
            csr_we    = cw;
            csr_wdata = wd;
            if (cw) exp_ff = wd;
            if (!kk) begin
                exp_ff   = exp_ff | rflg[u];
                exp_data = rres[u];
                exp_int  = idst;
            end
            step();
            quiet();
            chk("r_fflags", 32'(fflags), 32'(exp_ff));
            chk("r_valid", 32'(wb_valid), 32'(!kk));
            chk("r_data", wb_data, exp_data);
            chk("r_int", 32'(wb_int_dest), 32'(exp_int));
            if (!kk) begin
                dly = $urandom_range(0, 3);
                for (int c = 0; c < dly; c++) begin
                    step();
                    chk("r_hold_valid", 32'(wb_valid), 1);
                    chk("r_hold_data", wb_data, exp_data);
                end
                wb_ready = 1'b1;
                step();
                wb_ready = 1'b0;
            end
            chk("r_done_valid", 32'(wb_valid), 0);
            chk("r_done_busy", 32'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
